l1_mem_arbiter: RTL and testbench

- Shares the single external memory port between the instruction L1 cache (port 0) and the data L1 cache (port 1).
- Each cache controller issues whole-line refills (reads) and dirty-line write-backs (writes). The arbiter grants one requester at a time, drives the external memory handshake, and returns the read line together with a one-cycle ack.
- Sits between the two cache controllers and the CPU-level external memory signals.

---
 rtl/l1_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_l1_mem_arbiter.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one external memory port between the instruction
// L1 (port 0) and the data L1 (port 1). One whole-line transaction at a time:
// IDLE -> ISSUE (memory handshake) -> RESP (one-cycle ack) -> IDLE.
//
// Handshake summary: a requester raises reqN with weN/addrN/wdataN stable and
// holds it until ackN; ackN is a single-cycle pulse, rdataN is meaningful while
// ackN is high. Toward memory, mem_cs stays high with stable mem_we/mem_addr/
// mem_data_o until a mem_ack pulse; a mem_ack in the first mem_cs cycle is
// not a completion and is ignored.
module l1_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 256,
    parameter int DCACHE_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [LINE_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [LINE_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [LINE_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [LINE_WIDTH-1:0] rdata1,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LINE_WIDTH-1:0] mem_data_o,
    input  logic [LINE_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Byte-offset bits inside a 32-byte line; cleared on the memory address.
    localparam logic [ADDR_WIDTH-1:0] LINE_OFS_MASK = ADDR_WIDTH'(32'h1f);

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  rr_q, rr_d;        // port favoured on a simultaneous request
    logic                  first_q, first_d;  // high during the first ISSUE cycle
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [LINE_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  pick;

    // Arbitration: a lone requester wins; on a tie either port 1 (fixed
    // priority) or the port not served last (round-robin) wins.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = (DCACHE_PRIO != 0) ? 1'b1 : rr_q;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    // Next-state logic: latch the winner's request, wait for a valid
    // mem_ack, capture the read line, then spend one cycle acknowledging.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        first_d  = 1'b0;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ISSUE;
                    first_d = 1'b1;
                    grant_d = pick;
                    we_d    = pick ? we1 : we0;
                    addr_d  = (pick ? addr1 : addr0) & ~LINE_OFS_MASK;
                    wdata_d = pick ? wdata1 : wdata0;
                end
            end
            ISSUE: begin
                // An ack coinciding with the rising mem_cs cannot belong to
                // this access, so only later acks complete it.
                if (mem_ack && !first_q) begin
                    state_d = RESP;
                    if (grant_q) begin
                        rdata1_d = we_q ? '0 : mem_data_i;
                    end else begin
                        rdata0_d = we_q ? '0 : mem_data_i;
                    end
                end
            end
            RESP: begin
                rr_d    = ~grant_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            rr_q     <= 1'b0;
            first_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            first_q  <= first_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Outputs decode the registered state, so reset clears them at once.
    always_comb begin
        busy       = (state_q != IDLE);
        mem_cs     = (state_q == ISSUE);
        mem_we     = mem_cs & we_q;
        mem_addr   = mem_cs ? addr_q : '0;
        mem_data_o = mem_cs ? wdata_q : '0;
        ack0       = (state_q == RESP) && !grant_q;
        ack1       = (state_q == RESP) && grant_q;
        rdata0     = rdata0_q;
        rdata1     = rdata1_q;
        grant      = busy & grant_q;
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Bench for l1_mem_arbiter: directed scenarios plus randomized traffic from
// both ports, checked every cycle against a transaction-level model.
module tb_l1_mem_arbiter;

    localparam int AW     = 32;
    localparam int LW     = 256;
    localparam int PRIO_A = 0;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT A (round-robin) ----------------
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [LW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic [LW-1:0] rdata0, rdata1;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_data_o, mem_data_i;
    logic          mem_ack, busy, grant;

    l1_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DCACHE_PRIO(PRIO_A)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack(mem_ack), .busy(busy), .grant(grant)
    );

    // ---------------- DUT B (port 1 priority) ----------------
    logic          b_req0, b_we0, b_req1, b_we1;
    logic [AW-1:0] b_addr0, b_addr1;
    logic [LW-1:0] b_wdata0, b_wdata1;
    logic          b_ack0, b_ack1;
    logic [LW-1:0] b_rdata0, b_rdata1;
    logic          b_mem_cs, b_mem_we;
    logic [AW-1:0] b_mem_addr;
    logic [LW-1:0] b_mem_data_o, b_mem_data_i;
    logic          b_mem_ack, b_busy, b_grant;

    l1_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DCACHE_PRIO(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
        .mem_cs(b_mem_cs), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_data_o(b_mem_data_o),
        .mem_data_i(b_mem_data_i), .mem_ack(b_mem_ack), .busy(b_busy), .grant(b_grant)
    );

    // ---------------- counters and check helpers ----------------
    int n_run;
    int n_fail;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check(name, LW'(act), LW'(exp));
    endtask

    task automatic check_a(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        check(name, LW'(act), LW'(exp));
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        check(name, LW'(act), LW'(exp));
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        r      = a;
        r[4:0] = 5'b0;
        return r;
    endfunction

    // ---------------- memory responder for DUT A ----------------
    int            mem_delay;   // cycles after mem_cs rises until the real ack
    bit            spur_en;     // also pulse mem_ack in the first mem_cs cycle
    bit            rand_mode;
    logic [LW-1:0] fixed_line;
    logic [LW-1:0] exp_q[$];    // expected rdata of each completed transaction
    int            cs_cnt, cur_delay;
    bit            cur_spur;

    initial begin
        mem_ack    = 1'b0;
        mem_data_i = '0;
        cs_cnt     = 0;
        cur_delay  = 2;
        cur_spur   = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (rst || !mem_cs) begin
                cs_cnt = 0;
            end else begin
                cs_cnt++;
                if (cs_cnt == 1) begin
                    cur_delay = rand_mode ? int'($urandom_range(1, 5)) : mem_delay;
                    cur_spur  = rand_mode ? (cur_delay >= 2 && $urandom_range(0, 2) == 0) : spur_en;
                    if (cur_spur) begin
                        mem_ack    = 1'b1;
                        mem_data_i = rand_line();
                    end
                end else if (cs_cnt == cur_delay + 1) begin
                    mem_ack    = 1'b1;
                    mem_data_i = rand_mode ? rand_line() : fixed_line;
                    exp_q.push_back(mem_we ? '0 : mem_data_i);
                end
            end
        end
    end

    // ---------------- memory responder for DUT B ----------------
    int b_cnt;
    initial begin
        b_mem_ack    = 1'b0;
        b_mem_data_i = '0;
        b_cnt        = 0;
        forever begin
            @(posedge clk); #1;
            b_mem_ack = 1'b0;
            if (b_mem_cs) begin
                b_cnt++;
                if (b_cnt == 2) begin
                    b_mem_ack    = 1'b1;
                    b_mem_data_i = rand_line();
                end
            end else begin
                b_cnt = 0;
            end
        end
    end

    // ---------------- transaction-level model + per-cycle compare ----------------
    // m_owner: -1 when no transaction is open, else the port being served.
    int            m_owner;
    bit            m_resp, m_fresh;
    int            m_rr;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    logic [LW-1:0] m_line[2];

    always @(negedge clk) begin
        bit            e_busy, e_cs;
        int            w;
        logic [LW-1:0] e;
        if (rst) begin
            check_b("rst_ack0", ack0, 1'b0);
            check_b("rst_ack1", ack1, 1'b0);
            check("rst_rdata0", rdata0, '0);
            check("rst_rdata1", rdata1, '0);
            check_b("rst_mem_cs", mem_cs, 1'b0);
            check_b("rst_mem_we", mem_we, 1'b0);
            check_a("rst_mem_addr", mem_addr, '0);
            check("rst_mem_data_o", mem_data_o, '0);
            check_b("rst_busy", busy, 1'b0);
            check_b("rst_grant", grant, 1'b0);
            m_owner   = -1;
            m_resp    = 1'b0;
            m_fresh   = 1'b0;
            m_rr      = 0;
            m_we      = 1'b0;
            m_addr    = '0;
            m_wdata   = '0;
            m_line[0] = '0;
            m_line[1] = '0;
            exp_q.delete();
        end else begin
            e_busy = (m_owner >= 0);
            e_cs   = e_busy && !m_resp;
            check_b("busy", busy, e_busy);
            check_b("mem_cs", mem_cs, e_cs);
            check_b("ack0", ack0, m_resp && m_owner == 0);
            check_b("ack1", ack1, m_resp && m_owner == 1);
            if (e_busy) check_b("grant", grant, m_owner == 1);
            if (e_cs) begin
                check_a("mem_addr", mem_addr, line_of(m_addr));
                check_b("mem_we", mem_we, m_we);
                if (m_we) check("mem_data_o", mem_data_o, m_wdata);
            end
            if (m_resp && m_owner == 0) check("rdata0", rdata0, m_line[0]);
            if (m_resp && m_owner == 1) check("rdata1", rdata1, m_line[1]);
            if (ack0 || ack1) begin
                if (exp_q.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("FAIL sb_rdata: ack with no completed memory access, expected none (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_rdata", ack1 ? rdata1 : rdata0, e);
                end
            end
            // Advance the model by the clock edge that follows this sample.
            if (m_owner < 0) begin
                if (req0 || req1) begin
                    if (req0 && req1) w = (PRIO_A != 0) ? 1 : m_rr;
                    else w = req1 ? 1 : 0;
                    m_owner = w;
                    m_fresh = 1'b1;
                    m_we    = (w == 1) ? we1 : we0;
                    m_addr  = (w == 1) ? addr1 : addr0;
                    m_wdata = (w == 1) ? wdata1 : wdata0;
                end
            end else if (!m_resp) begin
                if (mem_ack && !m_fresh) begin
                    m_resp          = 1'b1;
                    m_line[m_owner] = m_we ? '0 : mem_data_i;
                end
                m_fresh = 1'b0;
            end else begin
                m_rr    = 1 - m_owner;
                m_owner = -1;
                m_resp  = 1'b0;
            end
        end
    end

    // ---------------- driver task ----------------
    int ack_order[$];

    task automatic run_txn(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [LW-1:0] wd, input bit solo,
                           output logic [AW-1:0] ma, output logic mwe,
                           output logic [LW-1:0] md, output logic [LW-1:0] rd,
                           output int lat);
        bit done;
        done = 1'b0;
        ma   = 'x;
        mwe  = 1'bx;
        md   = 'x;
        rd   = 'x;
        lat  = 0;
        if (p == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
        end
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (mem_cs && grant == p[0]) begin
                ma  = mem_addr;
                mwe = mem_we;
                md  = mem_data_o;
                check_a("txn_addr", mem_addr, line_of(a));
                check_b("txn_we", mem_we, we);
            end
            if (solo) check_b("other_ack", (p == 0) ? ack1 : ack0, 1'b0);
            if ((p == 0 && ack0) || (p == 1 && ack1)) begin
                rd   = (p == 0) ? rdata0 : rdata1;
                done = 1'b1;
                ack_order.push_back(p);
                if (p == 0) req0 = 1'b0;
                else req1 = 1'b0;
            end
        end
        if (!done) begin
            n_run++;
            n_fail++;
            $display("FAIL txn_timeout: port %0d got no ack in %0d cycles, expected one", p, lat);
            if (p == 0) req0 = 1'b0;
            else req1 = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [AW-1:0] ma;
        logic          mwe;
        logic [LW-1:0] md, rd, wd;
        int            lat;
        int            b_order[$];
        int            idle_between;
        bit            seen_cs;

        rst = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        b_req0 = 1'b0; b_we0 = 1'b0; b_addr0 = 32'h0000_011f; b_wdata0 = '0;
        b_req1 = 1'b0; b_we1 = 1'b0; b_addr1 = 32'h0000_0205; b_wdata1 = '0;
        mem_delay = 2; spur_en = 1'b0; rand_mode = 1'b0; fixed_line = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // 1: port 0 refill, ack two cycles after mem_cs
        mem_delay  = 2;
        fixed_line = {32{8'hA5}};
        run_txn(0, 1'b0, 32'h0000_1040, '0, 1'b1, ma, mwe, md, rd, lat);
        check_a("t1_addr", ma, 32'h0000_1040);
        check_b("t1_we", mwe, 1'b0);
        check("t1_rdata0", rd, {32{8'hA5}});
        check_i("t1_latency", lat, 4);

        // 2: port 1 write-back, fastest memory, offset bits cleared
        mem_delay = 1;
        wd = {16{16'h1234}};
        run_txn(1, 1'b1, 32'h0000_2013, wd, 1'b1, ma, mwe, md, rd, lat);
        check_a("t2_addr", ma, 32'h0000_2000);
        check_b("t2_we", mwe, 1'b1);
        check("t2_data_o", md, {16{16'h1234}});
        check("t2_rdata1", rd, '0);
        check_i("t2_latency", lat, 3);

        // 3: both ports requesting continuously, round-robin
        mem_delay = 2;
        ack_order.delete();
        fork
            begin : p0_t3
                logic [AW-1:0] ma0; logic mwe0; logic [LW-1:0] md0, rd0; int lat0;
                for (int i = 0; i < 2; i++) begin
                    run_txn(0, 1'b0, AW'(32'h3000 + i * 64), '0, 1'b0, ma0, mwe0, md0, rd0, lat0);
                    check_a("t3_addr0", ma0, AW'(32'h3000 + i * 64));
                    check("t3_rdata0", rd0, {32{8'hA5}});
                end
            end
            begin : p1_t3
                logic [AW-1:0] ma1; logic mwe1; logic [LW-1:0] md1, rd1; int lat1;
                for (int i = 0; i < 2; i++) begin
                    run_txn(1, 1'b1, AW'(32'h5007 + i * 64), '1, 1'b0, ma1, mwe1, md1, rd1, lat1);
                    check_a("t3_addr1", ma1, AW'(32'h5000 + i * 64));
                    check("t3_rdata1", rd1, '0);
                end
            end
        join
        check_i("t3_count", ack_order.size(), 4);
        for (int i = 0; i < 4 && i < ack_order.size(); i++) check_i("t3_order", ack_order[i], i % 2);

        // 4: fixed priority instance, simultaneous requests
        b_order.delete();
        idle_between = 0;
        seen_cs      = 1'b0;
        b_req0 = 1'b1;
        b_req1 = 1'b1;
        for (int c = 0; c < 60 && b_order.size() < 2; c++) begin
            @(posedge clk); #1;
            if (b_order.size() == 1 && !b_busy) idle_between++;
            if (b_mem_cs && !seen_cs) begin
                seen_cs = 1'b1;
                check_b("t4_first_grant", b_grant, 1'b1);
                check_a("t4_first_addr", b_mem_addr, 32'h0000_0200);
            end
            if (b_ack1) begin b_order.push_back(1); b_req1 = 1'b0; end
            if (b_ack0) begin b_order.push_back(0); b_req0 = 1'b0; end
        end
        b_req0 = 1'b0;
        b_req1 = 1'b0;
        check_i("t4_count", b_order.size(), 2);
        if (b_order.size() == 2) begin
            check_i("t4_order0", b_order[0], 1);
            check_i("t4_order1", b_order[1], 0);
        end
        check_i("t4_idle_cycles", idle_between, 1);

        // 5: asynchronous reset in the middle of ISSUE
        mem_delay = 1000;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_7000;
        repeat (3) begin @(posedge clk); #1; end
        check_b("t5_cs_before", mem_cs, 1'b1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_b("t5_mem_cs", mem_cs, 1'b0);
        check_b("t5_busy", busy, 1'b0);
        check_b("t5_ack0", ack0, 1'b0);
        check_b("t5_ack1", ack1, 1'b0);
        req0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_delay = 2;
        @(posedge clk); #1;
        run_txn(0, 1'b0, 32'h0000_7040, '0, 1'b1, ma, mwe, md, rd, lat);
        check_a("t5_addr", ma, 32'h0000_7040);
        check("t5_rdata0", rd, {32{8'hA5}});
        check_i("t5_latency", lat, 4);

        // 6: slow memory plus an ack coinciding with mem_cs rising
        mem_delay = 20;
        spur_en   = 1'b1;
        wd = rand_line();
        run_txn(0, 1'b1, 32'h0000_9abc, wd, 1'b1, ma, mwe, md, rd, lat);
        check_a("t6_addr", ma, 32'h0000_9aa0);
        check_b("t6_we", mwe, 1'b1);
        check("t6_data_o", md, wd);
        check("t6_rdata0", rd, '0);
        check_i("t6_latency", lat, 22);
        spur_en = 1'b0;

        // 7: randomized traffic on both ports
        rand_mode = 1'b1;
        fork
            begin : p0_rand
                logic [AW-1:0] ra; logic [LW-1:0] rw, rd0, md0; logic [AW-1:0] ma0; logic mwe0; int lat0;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    ra = $urandom;
                    rw = rand_line();
                    run_txn(0, 1'($urandom_range(0, 1)), ra, rw, 1'b0, ma0, mwe0, md0, rd0, lat0);
                end
            end
            begin : p1_rand
                logic [AW-1:0] ra; logic [LW-1:0] rw, rd1, md1; logic [AW-1:0] ma1; logic mwe1; int lat1;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    ra = $urandom;
                    rw = rand_line();
                    run_txn(1, 1'($urandom_range(0, 1)), ra, rw, 1'b0, ma1, mwe1, md1, rd1, lat1);
                end
            end
        join
        rand_mode = 1'b0;

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
